mac_window_sequencer: RTL

Producer side of the 3x3 MAC path. It accepts one 3x3 window (9 pixels and 9 weights) through a valid/ready handshake. It then issues the 9 operand pairs to the 8-bit multiplier, one pair per cycle, and drives the matching accumulator valid strobe aligned to the multiplier latency. Once the ninth product has been accumulated, it captures the accumulator output and presents it on a valid/ready result port. It keeps the accumulator's 9-count framing aligned by issuing exactly 9 products per window.

---
 rtl/mac_window_sequencer_pkg.sv | 28 ++
 rtl/mac_window_sequencer_if.sv | 37 +++
 rtl/mac_window_sequencer_valid_delay_line.sv | 44 ++++
 rtl/mac_window_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/mac_window_sequencer_pkg.sv
// Shared definitions for the 3x3 MAC window sequencer.
//   DATA_W / N_TAPS : operand width and taps per window
//   VEC_W           : width of a packed 9-tap pixel or weight vector
//   IDX_W           : width of the tap index
//   state_t         : sequencer states
//   tap_slice()     : extracts tap k from a packed vector (tap 0 in the LSBs)
package mac_window_sequencer_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned N_TAPS = 9;
   localparam int unsigned VEC_W  = DATA_W * N_TAPS;
   localparam int unsigned IDX_W  = $clog2(N_TAPS);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      HOLD
   } state_t;

   function automatic logic [DATA_W-1:0] tap_slice(
      input logic [VEC_W-1:0] vec,
      input logic [IDX_W-1:0] k
   );
      return vec[k*DATA_W +: DATA_W];
   endfunction

endpackage

// File: rtl/mac_window_sequencer_if.sv
// Bundle of every non-clock/reset signal of the window sequencer.
//   win_*  : window offer (valid/ready, 9 pixels, 9 weights)
//   mul_*  : operand pair to the multiplier
//   acc_*  : accumulator strobe out, registered accumulator sum in
//   res_*  : window result (valid/ready)
//   busy   : sequencer not in IDLE
// Modport master is the sequencer itself; slave is its environment.
interface mac_window_sequencer_if;
   import mac_window_sequencer_pkg::*;

   logic              win_valid;
   logic              win_ready;
   logic [VEC_W-1:0]  win_pix;
   logic [VEC_W-1:0]  win_wgt;
   logic [DATA_W-1:0] mul_a;
   logic [DATA_W-1:0] mul_b;
   logic              mul_valid;
   logic              acc_valid;
   logic [DATA_W-1:0] acc_sum;
   logic              res_valid;
   logic [DATA_W-1:0] res_data;
   logic              res_ready;
   logic              busy;

   modport master (
      input  win_valid, win_pix, win_wgt, acc_sum, res_ready,
      output win_ready, mul_a, mul_b, mul_valid, acc_valid,
             res_valid, res_data, busy
   );

   modport slave (
      output win_valid, win_pix, win_wgt, acc_sum, res_ready,
      input  win_ready, mul_a, mul_b, mul_valid, acc_valid,
             res_valid, res_data, busy
   );

endinterface

// File: rtl/mac_window_sequencer_valid_delay_line.sv
// Delays the multiplier valid by the multiplier latency so the strobe lines
// up with the product at the accumulator input.
//   clk, rst  : clock, asynchronous active-high reset (clears all stages)
//   valid_in  : mul_valid
//   valid_out : valid_in delayed by DEPTH cycles (DEPTH = 0 is a wire)
//   empty     : no valid in flight inside the line
module valid_delay_line #(
   parameter int unsigned DEPTH = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic valid_in,
   output logic valid_out,
   output logic empty
);

   if (DEPTH == 0) begin : g_pass
      // Nothing is stored, so clock and reset have no load here.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst;

      assign valid_out = valid_in;
      assign empty     = 1'b1;
   end else begin : g_shift
      logic [DEPTH-1:0] stage_q;

      // NOTE: non-blocking assignments make every stage load its neighbour's
      // pre-edge value; blocking ones would ripple valid_in through in one edge.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            stage_q <= '0;
         end else begin
            stage_q[0] <= valid_in;
            for (int i = 1; i < DEPTH; i++) begin
               stage_q[i] <= stage_q[i-1];
            end
         end
      end

      assign valid_out = stage_q[DEPTH-1];
      assign empty     = ~|stage_q;
   end

endmodule

// File: rtl/mac_window_sequencer.sv
// Producer side of the 3x3 MAC path. Accepts one window (9 pixels, 9 weights),
// issues the 9 operand pairs to the multiplier on consecutive cycles, strobes
// the accumulator MUL_LAT cycles later, then captures the accumulator sum and
// holds it on the result port until it is taken.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mac_window_sequencer_if.master (window, multiplier,
//              accumulator and result signals plus busy)
// MUL_LAT is the multiplier latency in cycles, legal range 0..4.
module mac_window_sequencer
   import mac_window_sequencer_pkg::*;
#(
   parameter int unsigned MUL_LAT = 1
) (
   input  logic                          clk,
   input  logic                          rst,
   mac_window_sequencer_if.master        bus
);

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VEC_W-1:0]  pix_q, wgt_q;
   logic [DATA_W-1:0] res_q;

   logic win_ready;
   logic mul_valid;
   logic res_valid;
   logic load;
   logic capture;
   logic dl_empty;

   valid_delay_line #(
      .DEPTH (MUL_LAT)
   ) u_valid_delay_line (
      .clk       (clk),
      .rst       (rst),
      .valid_in  (mul_valid),
      .valid_out (bus.acc_valid),
      .empty     (dl_empty)
   );

   // NOTE: every signal written here gets a default before the case, so no
   // state/branch combination can leave one unassigned and infer a latch.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      win_ready = 1'b0;
      mul_valid = 1'b0;
      res_valid = 1'b0;
      load      = 1'b0;
      capture   = 1'b0;

      case (state_q)
         IDLE: begin
            win_ready = 1'b1;
            if (bus.win_valid) begin
               load    = 1'b1;
               idx_d   = '0;
               state_d = ISSUE;
            end
         end

         ISSUE: begin
            mul_valid = 1'b1;
            if (idx_q == IDX_W'(N_TAPS - 1)) begin
               idx_d   = '0;
               state_d = DRAIN;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end

         // Once the delay line is empty the last strobe was the previous
         // cycle, so acc_sum now holds the finished window.
         DRAIN: begin
            if (dl_empty) begin
               capture = 1'b1;
               state_d = HOLD;
            end
         end

         HOLD: begin
            res_valid = 1'b1;
            if (bus.res_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         if (capture) begin
            res_q <= bus.acc_sum;
         end
      end
   end

   // NOTE: the window payload is left out of reset: it is only looked at in
   // ISSUE, which is always entered through a load that overwrites it.
   always_ff @(posedge clk) begin
      if (load) begin
         pix_q <= bus.win_pix;
         wgt_q <= bus.win_wgt;
      end
   end

   // Operands are forced to zero outside ISSUE so idle outputs stay quiet.
   assign bus.mul_a     = mul_valid ? tap_slice(pix_q, idx_q) : '0;
   assign bus.mul_b     = mul_valid ? tap_slice(wgt_q, idx_q) : '0;
   assign bus.mul_valid = mul_valid;
   assign bus.win_ready = win_ready;
   assign bus.res_valid = res_valid;
   assign bus.res_data  = res_q;
   assign bus.busy      = (state_q != IDLE);

endmodule
